// File: rtl/max_seq_arbiter.sv
// Round-robin scheduler that lends one shared max-finder datapath to NREQ requesters,
// one whole sequence at a time, and returns the tagged result over valid/ready.
module max_seq_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int MAXLEN  = 16,
  parameter int TIMEOUT = 32,
  localparam int IDW    = $clog2(NREQ),
  localparam int LW     = $clog2(MAXLEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic                 dp_start,
  output logic                 dp_valid,
  output logic [DW-1:0]        dp_data,
  output logic                 dp_last,
  input  logic                 dp_done,
  input  logic [DW-1:0]        dp_max,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDW-1:0]       res_id,
  output logic [DW-1:0]        res_max,
  output logic [LW-1:0]        res_len,
  output logic                 res_err,
  output logic                 res_trunc,
  output logic                 busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] LAST_IDX  = LW'(MAXLEN - 1);
  localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  gnt;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  rr_next;
  logic [LW-1:0]   count;
  logic [TW-1:0]   timer;
  logic [IDW-1:0]  pick;
  logic            pick_ok;
  logic            forced;

  // Priority search starting at rr_ptr and wrapping, so the last owner goes to the back.
  always_comb begin
    int idx;
    pick    = '0;
    pick_ok = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_ok && req_valid[IDW'(idx)]) begin
        pick    = IDW'(idx);
        pick_ok = 1'b1;
      end
    end
  end

  assign rr_next   = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_RESULT);

  always_comb begin
    state_nxt = state;
    dp_start  = 1'b0;
    dp_valid  = 1'b0;
    dp_data   = '0;
    dp_last   = 1'b0;
    req_ready = '0;
    forced    = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_ok) state_nxt = S_START;
      end
      S_START: begin
        dp_start  = 1'b1;
        state_nxt = S_STREAM;
      end
      S_STREAM: begin
        req_ready[gnt] = 1'b1;
        dp_valid       = req_valid[gnt];
        dp_data        = req_data[gnt*DW +: DW];
        forced         = (count == LAST_IDX);
        dp_last        = req_last[gnt] | forced;
        if (dp_valid && dp_last) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (dp_done || timer == TIMER_END) state_nxt = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result fields are only written on the way into RESULT, so they hold while res_valid is up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      count     <= '0;
      timer     <= '0;
      res_id    <= '0;
      res_max   <= '0;
      res_len   <= '0;
      res_err   <= 1'b0;
      res_trunc <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= (state == S_WAIT_DONE) ? timer + 1'b1 : '0;
      case (state)
        S_IDLE: begin
          if (pick_ok) gnt <= pick;
        end
        S_START: begin
          count <= '0;
        end
        S_STREAM: begin
          if (dp_valid) begin
            count <= count + 1'b1;
            if (dp_last) begin
              res_id    <= gnt;
              res_len   <= count + 1'b1;
              res_trunc <= forced & ~req_last[gnt];
            end
          end
        end
        S_WAIT_DONE: begin
          if (dp_done) begin
            res_max <= dp_max;
            res_err <= 1'b0;
          end else if (timer == TIMER_END) begin
            res_max <= '0;
            res_err <= 1'b1;
          end
        end
        S_RESULT: begin
          if (res_ready) rr_ptr <= rr_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_max_seq_arbiter.sv
// Directed bench for max_seq_arbiter: reset, single sequence, round-robin order,
// truncation, watchdog and result backpressure, each with hand-computed expectations.
module tb_max_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic        dp_done = 1'b0;
  logic [7:0]  dp_max = '0;
  logic        res_ready = 1'b0;

  logic [3:0]  req_ready;
  logic        dp_start, dp_valid, dp_last;
  logic [7:0]  dp_data;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [7:0]  res_max;
  logic [4:0]  res_len;
  logic        res_err, res_trunc, busy;

  int checks = 0;
  int failures = 0;
  int start_pulses = 0;

  wire [33:0] outs = {req_ready, dp_start, dp_valid, dp_data, dp_last, res_valid,
                      res_id, res_max, res_len, res_err, res_trunc, busy};

  max_seq_arbiter #(.NREQ(4), .DW(8), .MAXLEN(16), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .dp_start(dp_start), .dp_valid(dp_valid), .dp_data(dp_data), .dp_last(dp_last),
    .dp_done(dp_done), .dp_max(dp_max),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_max(res_max),
    .res_len(res_len), .res_err(res_err), .res_trunc(res_trunc), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dp_start) start_pulses++;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    req_valid = '0; req_last = '0; req_data = '0;
    dp_done = 1'b0; dp_max = '0; res_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
  endtask

  task automatic test_reset_state();
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== 34'h0) begin
      failures++;
      $display("[TB] FAIL reset_async: got %h expected %h", outs, 34'h0);
    end
    @(posedge clk); #2;
    checks++;
    if (outs !== 34'h0) begin
      failures++;
      $display("[TB] FAIL reset_held: got %h expected %h", outs, 34'h0);
    end
    rst = 1'b1;
    #1;
  endtask

  task automatic test_single();
    int base;
    base = start_pulses;
    req_valid = 4'b0010; req_data[15:8] = 8'd5; req_last = 4'b0000;
    tick();
    checks++;
    if ({dp_start, dp_valid, req_ready, busy} !== {1'b1, 1'b0, 4'b0000, 1'b1}) begin
      failures++;
      $display("[TB] FAIL single_start: got %b expected %b", {dp_start, dp_valid, req_ready, busy}, 7'b1000001);
    end
    tick();
    checks++;
    if ({dp_valid, dp_data, req_ready, dp_last, dp_start} !== {1'b1, 8'd5, 4'b0010, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL single_beat1: got %h expected %h", {dp_valid, dp_data, req_ready, dp_last, dp_start},
               {1'b1, 8'd5, 4'b0010, 1'b0, 1'b0});
    end
    tick();
    req_data[15:8] = 8'd9;
    #1;
    checks++;
    if (dp_data !== 8'd9) begin
      failures++;
      $display("[TB] FAIL single_beat2: got %0d expected %0d", dp_data, 9);
    end
    tick();
    req_data[15:8] = 8'd3; req_last = 4'b0010;
    #1;
    checks++;
    if ({dp_last, dp_data} !== {1'b1, 8'd3}) begin
      failures++;
      $display("[TB] FAIL single_last: got %h expected %h", {dp_last, dp_data}, {1'b1, 8'd3});
    end
    tick();
    req_valid = '0; req_last = '0;
    tick();
    tick();
    dp_done = 1'b1; dp_max = 8'd9;
    tick();
    dp_done = 1'b0;
    checks++;
    if ({res_valid, res_id, res_max, res_len, res_err, res_trunc} !==
        {1'b1, 2'd1, 8'd9, 5'd3, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL single_result: got %h expected %h",
               {res_valid, res_id, res_max, res_len, res_err, res_trunc},
               {1'b1, 2'd1, 8'd9, 5'd3, 1'b0, 1'b0});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if ({busy, res_valid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL single_idle: got %b expected %b", {busy, res_valid}, 2'b00);
    end
    checks++;
    if (start_pulses - base !== 1) begin
      failures++;
      $display("[TB] FAIL single_start_count: got %0d expected %0d", start_pulses - base, 1);
    end
  endtask

  task automatic test_reset_mid_stream();
    req_valid = 4'b0101; req_last = 4'b0000;
    req_data[7:0] = 8'h11; req_data[23:16] = 8'h22;
    tick();
    tick();
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL rr_after_single: got %b expected %b", req_ready, 4'b0100);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== 34'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid_stream: got %h expected %h", outs, 34'h0);
    end
    @(posedge clk); #2;
    checks++;
    if (outs !== 34'h0) begin
      failures++;
      $display("[TB] FAIL reset_next_cycle: got %h expected %h", outs, 34'h0);
    end
    rst = 1'b1; req_last = 4'b0101;
    #1;
    tick();
    tick();
    checks++;
    if ({req_ready, dp_data, dp_last} !== {4'b0001, 8'h11, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_first_grant: got %h expected %h", {req_ready, dp_data, dp_last},
               {4'b0001, 8'h11, 1'b1});
    end
    tick();
    req_valid = '0; req_last = '0;
    dp_done = 1'b1; dp_max = 8'h11;
    tick();
    dp_done = 1'b0;
    checks++;
    if ({res_id, res_len} !== {2'd0, 5'd1}) begin
      failures++;
      $display("[TB] FAIL reset_seq_result: got %h expected %h", {res_id, res_len}, {2'd0, 5'd1});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int order [7];
    logic [3:0] expv;
    int n;
    order = '{0, 1, 2, 3, 0, 1, 2};
    do_reset();
    req_valid = 4'b1111; req_last = 4'b1111;
    req_data = 32'h03020100;
    dp_done = 1'b1; dp_max = 8'h05; res_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      expv = (s < 7) ? (4'b0001 << order[s]) : 4'b0001;
      n = 0;
      @(negedge clk);
      while (req_ready == 4'b0000 && n < 20) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (req_ready !== expv) begin
        failures++;
        $display("[TB] FAIL rr_grant_%0d: got %b expected %b", s, req_ready, expv);
      end
      if (s == 6) req_valid = 4'b0101;
    end
    tick();
    req_valid = '0; req_last = '0;
    repeat (4) tick();
    dp_done = 1'b0; res_ready = 1'b0;
  endtask

  task automatic test_truncation();
    do_reset();
    req_valid = 4'b0100; req_last = 4'b0000;
    tick();
    tick();
    for (int b = 1; b <= 16; b++) begin
      req_data[23:16] = 8'(b);
      #1;
      if (b >= 15) begin
        checks++;
        if ({dp_last, req_ready, dp_data} !== {(b == 16), 4'b0100, 8'(b)}) begin
          failures++;
          $display("[TB] FAIL trunc_beat_%0d: got %h expected %h", b, {dp_last, req_ready, dp_data},
                   {(b == 16), 4'b0100, 8'(b)});
        end
      end
      tick();
    end
    req_data[23:16] = 8'd17;
    #1;
    checks++;
    if ({req_ready, dp_valid} !== {4'b0000, 1'b0}) begin
      failures++;
      $display("[TB] FAIL trunc_ready_drop: got %b expected %b", {req_ready, dp_valid}, 5'b00000);
    end
    dp_done = 1'b1; dp_max = 8'd16;
    tick();
    dp_done = 1'b0; req_valid = '0;
    checks++;
    if ({res_valid, res_id, res_max, res_len, res_trunc, res_err} !==
        {1'b1, 2'd2, 8'd16, 5'd16, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL trunc_result: got %h expected %h",
               {res_valid, res_id, res_max, res_len, res_trunc, res_err},
               {1'b1, 2'd2, 8'd16, 5'd16, 1'b1, 1'b0});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_watchdog();
    req_valid = 4'b0010; req_last = 4'b0010; req_data[15:8] = 8'h42;
    tick();
    tick();
    tick();
    req_valid = '0; req_last = '0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 31) begin
        checks++;
        if (res_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL wd_early: got %b expected %b", res_valid, 1'b0);
        end
      end
    end
    checks++;
    if ({res_valid, res_err, res_max, res_id, res_len} !== {1'b1, 1'b1, 8'h00, 2'd1, 5'd1}) begin
      failures++;
      $display("[TB] FAIL wd_expire: got %h expected %h", {res_valid, res_err, res_max, res_id, res_len},
               {1'b1, 1'b1, 8'h00, 2'd1, 5'd1});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    req_valid = 4'b0010; req_last = 4'b0010;
    tick();
    tick();
    tick();
    req_valid = '0; req_last = '0;
    repeat (31) tick();
    dp_done = 1'b1; dp_max = 8'hA5;
    tick();
    dp_done = 1'b0;
    checks++;
    if ({res_valid, res_err, res_max} !== {1'b1, 1'b0, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL wd_done_wins: got %h expected %h", {res_valid, res_err, res_max}, {1'b1, 1'b0, 8'hA5});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [33:0] expv;
    req_valid = 4'b1000; req_last = 4'b1000; req_data[31:24] = 8'h77;
    tick();
    tick();
    tick();
    req_valid = '0;
    dp_done = 1'b1; dp_max = 8'h77;
    tick();
    dp_done = 1'b0;
    expv = {4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 8'h77, 5'd1, 1'b0, 1'b0, 1'b1};
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      dp_done = (c == 4);
      dp_max  = (c == 4) ? 8'hFF : 8'h00;
      tick();
      checks++;
      if (outs !== expv) begin
        failures++;
        $display("[TB] FAIL bp_hold_%0d: got %h expected %h", c, outs, expv);
      end
    end
    dp_done = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if ({busy, res_valid, req_ready} !== {1'b0, 1'b0, 4'b0000}) begin
      failures++;
      $display("[TB] FAIL bp_release: got %b expected %b", {busy, res_valid, req_ready}, 6'b000000);
    end
    tick();
    tick();
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL bp_next_grant: got %b expected %b", req_ready, 4'b0001);
    end
    tick();
    req_valid = '0; req_last = '0;
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #1;
    test_reset_state();
    test_single();
    test_reset_mid_stream();
    test_round_robin();
    test_truncation();
    test_watchdog();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
